// File: rtl/demux32_buf_if.sv
// Port bundle for demux32_buf: one input stream and two independently drained output channels.
// The master side drives the input word and the consumer ready signals.
interface demux32_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [LW-1:0]    out0_level;
  logic [LW-1:0]    out1_level;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, out0_level, out1_level
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, out0_level, out1_level
  );
endinterface

// File: rtl/demux32_buf.sv
// Buffered 1-to-2 demux: each accepted word is steered by in_sel into one of two small FIFOs.
// Full/empty comes from a per-channel level counter; storage itself is never reset.
module demux32_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  demux32_buf_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0][LW-1:0]    level;
  logic [1:0][WIDTH-1:0] head;
  logic [1:0]            valid;
  logic [1:0]            out_ready;
  logic [1:0]            sel_onehot;
  logic                  in_fire;

  // Input readiness looks only at the selected channel's registered level.
  assign bus.in_ready = (level[bus.in_sel] != LW'(DEPTH));
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign sel_onehot   = {bus.in_sel, !bus.in_sel};
  assign out_ready    = {bus.out1_ready, bus.out0_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [LW-1:0]    level_q, level_d;
      logic             push;
      logic             pop;

      assign push = in_fire && sel_onehot[gi];
      assign pop  = (level_q != '0) && out_ready[gi];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          level_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          level_q  <= level_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= bus.in_data;
      end

      // Empty channels present zero so stale storage never leaks out.
      assign valid[gi] = (level_q != '0);
      assign head[gi]  = valid[gi] ? mem_q[rd_ptr_q] : '0;
      assign level[gi] = level_q;
    end
  endgenerate

  assign bus.out0_data  = head[0];
  assign bus.out1_data  = head[1];
  assign bus.out0_valid = valid[0];
  assign bus.out1_valid = valid[1];
  assign bus.out0_level = level[0];
  assign bus.out1_level = level[1];
endmodule

// File: tb/tb_demux32_buf.sv
// Directed and randomized checks for demux32_buf; inputs change 1 time unit after rising edges.
module tb_demux32_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  demux32_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux32_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
  endtask

  task automatic push_word(input logic sel, input logic [WIDTH-1:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    step();
    bus.in_valid = 1'b0;
    $display("push sel=%0d data=%h lvl0=%0d lvl1=%0d", sel, data, bus.out0_level, bus.out1_level);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h12345678;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.out0_level !== '0 || bus.out1_level !== '0) $display("FAIL reset_level: got %0d/%0d expected 0/0", bus.out0_level, bus.out1_level); else passes++;
      checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) $display("FAIL reset_valid: got %b/%b expected 0/0", bus.out0_valid, bus.out1_valid); else passes++;
      checks++; if (bus.out0_data !== '0 || bus.out1_data !== '0) $display("FAIL reset_data: got %h/%h expected 0/0", bus.out0_data, bus.out1_data); else passes++;
    end
    bus.in_sel = 1'b0; #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready_sel0: got %b expected 1", bus.in_ready); else passes++;
    bus.in_sel = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready_sel1: got %b expected 1", bus.in_ready); else passes++;
    idle_inputs();
    rst = 1'b0;
    push_word(1'b1, 32'hDEADBEEF);
    checks++; if (bus.out1_data !== 32'hDEADBEEF || bus.out1_valid !== 1'b1) $display("FAIL first_push_ch1: got %h v=%b expected deadbeef v=1", bus.out1_data, bus.out1_valid); else passes++;
    checks++; if (bus.out1_level !== LW'(1) || bus.out0_level !== '0 || bus.out0_valid !== 1'b0) $display("FAIL first_push_levels: got %0d/%0d v0=%b expected 0/1 v0=0", bus.out0_level, bus.out1_level, bus.out0_valid); else passes++;
    bus.out1_ready = 1'b1; step(); bus.out1_ready = 1'b0;
    checks++; if (bus.out1_level !== '0) $display("FAIL first_drain: got %0d expected 0", bus.out1_level); else passes++;
  endtask

  task automatic test_backpressure();
    idle_inputs();
    push_word(1'b0, 32'h11);
    push_word(1'b0, 32'h22);
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'h33; #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", bus.in_ready); else passes++;
    step();
    checks++; if (bus.out0_level !== LW'(2) || bus.out1_level !== '0) $display("FAIL bp_levels: got %0d/%0d expected 2/0", bus.out0_level, bus.out1_level); else passes++;
    bus.in_sel = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_other_ready: got %b expected 1", bus.in_ready); else passes++;
    step(); bus.in_valid = 1'b0;
    checks++; if (bus.out1_level !== LW'(1) || bus.out1_data !== 32'h33) $display("FAIL bp_ch1_word: got lvl=%0d data=%h expected 1 00000033", bus.out1_level, bus.out1_data); else passes++;
    bus.out0_ready = 1'b1; #1;
    checks++; if (bus.out0_data !== 32'h11) $display("FAIL bp_drain_first: got %h expected 00000011", bus.out0_data); else passes++;
    step();
    checks++; if (bus.out0_data !== 32'h22) $display("FAIL bp_drain_second: got %h expected 00000022", bus.out0_data); else passes++;
    step();
    checks++; if (bus.out0_valid !== 1'b0 || bus.out0_data !== '0) $display("FAIL bp_drain_empty: got v=%b data=%h expected 0/0", bus.out0_valid, bus.out0_data); else passes++;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b1; step(); bus.out1_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    idle_inputs();
    push_word(1'b0, 32'hA);
    push_word(1'b0, 32'hB);
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 32'hC; bus.out0_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out0_data !== 32'hA) $display("FAIL fp_full: got ready=%b head=%h expected 0 0000000a", bus.in_ready, bus.out0_data); else passes++;
    step();
    checks++; if (bus.out0_level !== LW'(1) || bus.out0_data !== 32'hB) $display("FAIL fp_pop_only: got lvl=%0d head=%h expected 1 0000000b", bus.out0_level, bus.out0_data); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL fp_ready_after: got %b expected 1", bus.in_ready); else passes++;
    step(); bus.in_valid = 1'b0;
    checks++; if (bus.out0_level !== LW'(1) || bus.out0_data !== 32'hC) $display("FAIL fp_push_pop: got lvl=%0d head=%h expected 1 0000000c", bus.out0_level, bus.out0_data); else passes++;
    step(); bus.out0_ready = 1'b0;
    checks++; if (bus.out0_level !== '0) $display("FAIL fp_final_drain: got %0d expected 0", bus.out0_level); else passes++;
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] got;
    logic [LW-1:0]    lsel, loth;
    idle_inputs();
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_sel = i[0]; bus.in_data = WIDTH'(i);
      step();
      got  = i[0] ? bus.out1_data  : bus.out0_data;
      lsel = i[0] ? bus.out1_level : bus.out0_level;
      loth = i[0] ? bus.out0_level : bus.out1_level;
      $display("wrap word=%0d ch=%0d head=%h", i, i[0], got);
      checks++; if (got !== WIDTH'(i) || lsel !== LW'(1) || loth !== '0) $display("FAIL wrap_%0d: got head=%h lvl=%0d/%0d expected %h 1/0", i, got, lsel, loth, WIDTH'(i)); else passes++;
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out0_level !== '0 || bus.out1_level !== '0) $display("FAIL wrap_end: got %0d/%0d expected 0/0", bus.out0_level, bus.out1_level); else passes++;
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    push_word(1'b0, 32'h1);
    push_word(1'b1, 32'h3);
    push_word(1'b0, 32'h2);
    push_word(1'b1, 32'h4);
    checks++; if (bus.out0_level !== LW'(2) || bus.out1_level !== LW'(2)) $display("FAIL mid_prefill: got %0d/%0d expected 2/2", bus.out0_level, bus.out1_level); else passes++;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 32'h99;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    step();
    rst = 1'b0; idle_inputs();
    checks++; if (bus.out0_level !== '0 || bus.out1_level !== '0 || bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) $display("FAIL mid_reset: got lvl=%0d/%0d v=%b/%b expected 0/0 0/0", bus.out0_level, bus.out1_level, bus.out0_valid, bus.out1_valid); else passes++;
    push_word(1'b0, 32'h55);
    checks++; if (bus.out0_data !== 32'h55 || bus.out0_level !== LW'(1) || bus.out1_valid !== 1'b0) $display("FAIL mid_post_push: got head=%h lvl=%0d v1=%b expected 00000055 1 0", bus.out0_data, bus.out0_level, bus.out1_valid); else passes++;
    bus.out0_ready = 1'b1; step(); bus.out0_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic             exp_ready, do_push, pop0, pop1;
    logic [WIDTH-1:0] exp0, exp1;
    int               errs;
    errs = 0;
    idle_inputs();
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_sel     = 1'($urandom_range(0, 1));
      bus.in_data    = $urandom;
      bus.out0_ready = 1'($urandom_range(0, 1));
      bus.out1_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ready = bus.in_sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
      exp0 = (q0.size() != 0) ? q0[0] : '0;
      exp1 = (q1.size() != 0) ? q1[0] : '0;
      checks++; if (bus.in_ready !== exp_ready) begin errs++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", c, bus.in_ready, exp_ready); end else passes++;
      checks++; if ({bus.out0_level, bus.out1_level} !== {LW'(q0.size()), LW'(q1.size())}) begin errs++; $display("FAIL rnd_level cyc=%0d: got %0d/%0d expected %0d/%0d", c, bus.out0_level, bus.out1_level, q0.size(), q1.size()); end else passes++;
      checks++; if ({bus.out0_valid, bus.out0_data} !== {q0.size() != 0, exp0}) begin errs++; $display("FAIL rnd_out0 cyc=%0d: got v=%b %h expected v=%b %h", c, bus.out0_valid, bus.out0_data, q0.size() != 0, exp0); end else passes++;
      checks++; if ({bus.out1_valid, bus.out1_data} !== {q1.size() != 0, exp1}) begin errs++; $display("FAIL rnd_out1 cyc=%0d: got v=%b %h expected v=%b %h", c, bus.out1_valid, bus.out1_data, q1.size() != 0, exp1); end else passes++;
      do_push = bus.in_valid && exp_ready;
      pop0    = bus.out0_ready && (q0.size() != 0);
      pop1    = bus.out1_ready && (q1.size() != 0);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (do_push) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q0.push_back(bus.in_data);
      end
      step();
    end
    $display("random cross-check: 10000 cycles, %0d errors", errs);
    idle_inputs();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    passes = 0;
    idle_inputs();
    test_reset();
    test_backpressure();
    test_full_pushpop();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/demux32_buf.md
# demux32_buf

Buffered 1-to-2 demultiplexer for 32-bit datapath words: each accepted input word is steered by a select bit into one of two per-channel FIFOs, each drained independently through a valid/ready handshake. It is the distribution counterpart of the 2:1 32-bit select mux, used where one result source feeds two consumers running at different rates, such as write-back versus a store/debug port. Per-channel ordering is preserved. Channels never block each other except through the shared input port.

## Interface
- WIDTH, 32, data word width
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to distribute
- in_sel  input  1  destination: 1 → channel 1, 0 → channel 0
- in_valid  input  1  in_data/in_sel are valid this cycle
- in_ready  output  1  selected channel can accept this cycle
- out0_data  output  WIDTH  channel 0 head word
- out0_valid  output  1  channel 0 non-empty
- out0_ready  input  1  channel 0 consumer accepts head
- out1_data  output  WIDTH  channel 1 head word
- out1_valid  output  1  channel 1 non-empty
- out1_ready  input  1  channel 1 consumer accepts head
- out0_level  output  clog2(DEPTH)+1  channel 0 occupancy, 0..DEPTH
- out1_level  output  clog2(DEPTH)+1  channel 1 occupancy, 0..DEPTH

## Operation
- Push: occurs when in_valid && in_ready. The word is written at the write pointer of channel in_sel, that pointer increments, and the level increments.
- in_ready = (level[in_sel] != DEPTH). It is combinational on in_sel and the registered level only; it never depends on outX_ready. A full channel blocks input even if its consumer pops in the same cycle.
- Pop on channel k: occurs when outk_valid && outk_ready. The read pointer increments and the level decrements.
- outk_valid = (levelk != 0).
- outk_data = entry at the read pointer when valid. It is forced to 0 when empty.
- Simultaneous push and pop on the same channel: both take effect, and the level is unchanged.
- Push to one channel and pop from the other in the same cycle: independent; each level moves by ±1.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is decided by level, not by pointer comparison.
- Non-selected channel: no state change from the input side.
- While in_valid is low, in_sel and in_data are ignored.
- outk_ready while empty: ignored, with no pointer or level change.
- Storage memory is not reset. Only pointers and levels are reset, so no stale word is ever presented as valid.

## Timing
- Reset: after any cycle with rst=1, all pointers and levels are 0. out0_valid=out1_valid=0, out0_data=out1_data=0, out0_level=out1_level=0, and in_ready=1 for both sel values.
- Reset mid-operation: all buffered words are discarded in that cycle. A push or pop presented during rst is not performed.
- Latency: a word pushed at edge N is visible on outk_data with outk_valid=1 after edge N; it can be popped at edge N+1 at the earliest. There is no combinational input→output bypass.
- Throughput: one push per cycle (to either channel) and one pop per channel per cycle, for up to 3 transfers per cycle.
- Level outputs are registered and reflect the state after the last edge.

## Test plan
- Reset/idle: hold rst=1 for 2 cycles with in_valid=1 → levels stay 0, both out_valid=0, both out_data=0, in_ready=1. After release, a push of 0xDEADBEEF with sel=1 → out1_data=0xDEADBEEF, out1_valid=1, out1_level=1, and channel 0 is untouched.
- Fill and backpressure: out0_ready=0; push 0x11, 0x22, 0x33 with sel=0 → first two accepted, out0_level=2, in_ready=0 on the third. Switching sel=1 gives in_ready=1 and 0x33 goes to channel 1. Then drain channel 0 → 0x11 then 0x22, in order.
- Simultaneous push/pop when full: channel 0 full (0xA, 0xB), out0_ready=1, push 0xC with sel=0 → in_ready=0, so no push. The pop of 0xA occurs and the level becomes 1. The next cycle 0xC is accepted and the level stays 1 (push plus pop of 0xB).
- Wrap-around: stream 0x0..0x9 alternating sel with both readers always ready → each channel outputs its 5 words in order (ch0: 0,2,4,6,8; ch1: 1,3,5,7,9), each exactly one cycle after its push, and levels never exceed 1.
- Reset mid-stream: both channels at level 2, assert rst for one cycle while pushing and popping → levels 0, valids 0. The first post-reset push of 0x55 with sel=0 appears as the channel 0 head, with no stale data.
- Randomized cross-check: random in_valid, in_sel, and outk_ready for 10k cycles against a two-queue reference model → per-channel order, levels, and in_ready match every cycle.
